// File: rtl/divider_seq.sv
// divider_seq: iterative restoring divider, one quotient bit per clock, start/working/done handshake.
// Ports: clk, reset (async active-low), div (start strobe), sign (signed mode), a (dividend), b (divisor),
//        working (op in flight), done (one-cycle result pulse), div_by_zero, quotient, remainder.
// Vectors are declared [0:WIDTH-1], so bit 0 is the MSB.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div,
    input  logic             sign,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             working,
    output logic             done,
    output logic             div_by_zero,
    output logic [0:WIDTH-1] quotient,
    output logic [0:WIDTH-1] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t           state;
    logic [WIDTH-1:0] dvd, dsr, rem, a_mag, b_mag;
    logic [CW-1:0]    count;
    logic             quot_neg, rem_neg, zero;
    logic [WIDTH:0]   shifted, diff;
    assign a_mag   = (sign && a[0]) ? -a : a;
    assign b_mag   = (sign && b[0]) ? -b : b;
    // dvd doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom
    assign shifted = {rem, dvd[WIDTH-1]};
    // one extra bit so a 2^(WIDTH-1) magnitude divisor still subtracts correctly
    assign diff    = shifted - {1'b0, dsr};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            working     <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            count       <= '0;
            quot_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            zero        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (div && !done) begin
                    working     <= 1'b1;
                    div_by_zero <= 1'b0;
                    quot_neg    <= sign & (a[0] ^ b[0]);
                    rem_neg     <= sign & a[0];
                    dsr         <= b_mag;
                    rem         <= '0;
                    count       <= CW'(WIDTH);
                    zero        <= (b == '0);
                    // on divide by zero the raw dividend is kept for the remainder
                    dvd         <= (b == '0) ? a : a_mag;
                    state       <= (b == '0) ? FINISH : RUN;
                end
                RUN: begin
                    rem   <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
                    count <= count - 1'b1;
                    state <= (count == CW'(1)) ? FINISH : RUN;
                end
                FINISH: begin
                    working     <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= zero;
                    quotient    <= zero ? '1 : (quot_neg ? -dvd : dvd);
                    remainder   <= zero ? dvd : (rem_neg ? -rem : rem);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized self-checking bench for divider_seq against a latency/arithmetic reference model.
module tb_divider_seq;
    logic        clk = 1'b0;
    logic        reset, div, sign_i;
    logic [0:31] a_i, b_i;
    logic        working, done, div_by_zero;
    logic [0:31] quotient, remainder;
    int          n = 0, fails = 0;

    int          left = 0;
    logic        e_done = 0, e_work = 0, e_dz = 0, pdz = 0, done_old;
    logic [31:0] e_q = 0, e_r = 0, pq = 0, pr = 0;

    divider_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .div(div), .sign(sign_i), .a(a_i), .b(b_i),
        .working(working), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (y == 0) begin
            q = '1;
            r = x;
        end else if (s) begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    task automatic model_clear();
        left = 0; e_done = 0; e_work = 0; e_dz = 0; e_q = 0; e_r = 0;
    endtask

    // Reference model: results from plain arithmetic, timing from the documented latency
    initial forever begin
        @(posedge clk);
        if (!reset) model_clear();
        else if (left > 0) begin
            left--;
            e_done = (left == 0);
            if (left == 0) begin
                e_q = pq; e_r = pr; e_dz = pdz;
            end
        end else begin
            done_old = e_done;
            e_done = 0;
            if (div && !done_old) begin
                ref_div(a_i, b_i, sign_i, pq, pr);
                pdz  = (b_i == 0);
                e_dz = 0;
                left = pdz ? 1 : 33;
            end
        end
        e_work = (left > 0);
        @(negedge clk);
        if (!reset) model_clear();
        chk("working", working, e_work);
        chk("done", done, e_done);
        chk("div_by_zero", div_by_zero, e_dz);
        chk("quotient", quotient, e_q);
        chk("remainder", remainder, e_r);
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output int edges, output int wcnt, output logic got);
        @(posedge clk); #1;
        div = 1; a_i = x; b_i = y; sign_i = s;
        @(posedge clk); #1;
        div = 0;
        edges = 1; wcnt = 0; got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                if (working) wcnt++;
                @(posedge clk);
                edges++;
            end
        end
        chk("done_seen", got, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   edges, wcnt, nd;
        logic got;
        logic [31:0] x, y, qd, rd;
        reset = 0; div = 0; a_i = 0; b_i = 0; sign_i = 0;
        #12;
        chk("rst_working", working, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        @(posedge clk); #1 reset = 1;

        run_op(100, 7, 0, edges, wcnt, got);
        chk("u_q", quotient, 14);
        chk("u_r", remainder, 2);
        chk("u_dz", div_by_zero, 0);
        chk("u_latency", edges, 34);
        chk("u_working_cycles", wcnt, 33);

        run_op(32'hFFFFFF9C, 7, 1, edges, wcnt, got);
        chk("s1_q", quotient, 32'hFFFFFFF2);
        chk("s1_r", remainder, 32'hFFFFFFFE);

        run_op(100, 32'hFFFFFFF9, 1, edges, wcnt, got);
        chk("s2_q", quotient, 32'hFFFFFFF2);
        chk("s2_r", remainder, 2);

        run_op(32'h1234, 0, 0, edges, wcnt, got);
        chk("dz_q", quotient, 32'hFFFFFFFF);
        chk("dz_r", remainder, 32'h1234);
        chk("dz_flag", div_by_zero, 1);
        chk("dz_latency", edges, 2);

        run_op(9, 3, 0, edges, wcnt, got);
        chk("dz_clear", div_by_zero, 0);
        chk("n_q", quotient, 3);

        run_op(32'h80000000, 32'hFFFFFFFF, 1, edges, wcnt, got);
        chk("ovf_q", quotient, 32'h80000000);
        chk("ovf_r", remainder, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, 0, edges, wcnt, got);
        chk("uw_q", quotient, 0);
        chk("uw_r", remainder, 32'h80000000);

        // second start while busy must be dropped
        @(posedge clk); #1;
        div = 1; a_i = 100; b_i = 7; sign_i = 0;
        @(posedge clk); #1 div = 0;
        repeat (9) @(posedge clk);
        #1 div = 1; a_i = 50; b_i = 5;
        @(posedge clk); #1 div = 0;
        nd = 0; qd = 0; rd = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) begin
                nd++; qd = quotient; rd = remainder;
            end
        end
        chk("busy_done_count", nd, 1);
        chk("busy_q", qd, 14);
        chk("busy_r", rd, 2);

        // asynchronous abort mid-operation
        @(posedge clk); #1;
        div = 1; a_i = 100; b_i = 7; sign_i = 0;
        @(posedge clk); #1 div = 0;
        repeat (15) @(posedge clk);
        #3 reset = 0;
        #1;
        chk("ar_working", working, 0);
        chk("ar_done", done, 0);
        chk("ar_quotient", quotient, 0);
        chk("ar_remainder", remainder, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        run_op(9, 3, 0, edges, wcnt, got);
        chk("ar_q", quotient, 3);
        chk("ar_r", remainder, 0);
        chk("ar_latency", edges, 34);

        for (int k = 0; k < 30; k++) begin
            x = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: y = 0;
                1: y = 32'hFFFFFFFF;
                2: y = $urandom_range(1, 20);
                default: y = $urandom;
            endcase
            run_op(x, y, 1'($urandom_range(0, 1)), edges, wcnt, got);
            chk("rand_latency", edges, (y == 0) ? 2 : 34);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
